regfile_mp: RTL
===============

Name: regfile_mp

Overview:
Parametrised multi-port integer register file, the successor to the single-write, dual-read core register file. It is used by the wider-issue pipeline:
- N asynchronous read ports, M synchronous write ports.
- Write-through forwarding with deterministic port priority.
- Per-entry valid bits with asynchronous reset and a one-cycle bulk clear.
- A ready/valid dump sequencer that streams the whole file out, for debug and for the test harness.

Parameters:
XLEN, 32, data width of each register
DEPTH, 32, number of registers; power of two, at least 2
NUM_RD, 2, number of read ports
NUM_WR, 1, number of write ports
ZERO_REG, 1, when 1, entry 0 reads as 0 and ignores writes
SP_INDEX, 2, entry whose reset/cleared value is SP_INIT
SP_INIT, 32'h02000000, reset/cleared value of entry SP_INDEX; all other entries reset/clear to 0
AW, $clog2(DEPTH), derived index width (localparam)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
rd_index  in  NUM_RD*AW  read indices, port p at [p*AW +: AW]
rd_data  out  NUM_RD*XLEN  read data, port p at [p*XLEN +: XLEN]
wr_enable  in  NUM_WR  per-port write enable
wr_index  in  NUM_WR*AW  write indices
wr_data  in  NUM_WR*XLEN  write data
clear  in  1  synchronous bulk clear of all entries
dump_start  in  1  starts a dump when idle
dump_busy  out  1  dump sequencer not idle
dump_valid  out  1  dump beat valid
dump_ready  in  1  consumer accepts beat
dump_index  out  AW  entry index of current beat
dump_data  out  XLEN  entry value of current beat
dump_last  out  1  current beat is entry DEPTH-1

Behaviour:
- Storage: array of DEPTH x XLEN plus valid[DEPTH].
  - Effective value of entry i = valid[i] ? array[i] : init(i).
  - init(SP_INDEX) = SP_INIT; init(i) = 0 for every other i.
- Reset (rst=1, asynchronous): all valid bits cleared, dump FSM to IDLE.
  - Output reset values: dump_busy=0, dump_valid=0, dump_last=0, dump_index=0, dump_data=0.
  - The array contents themselves are not reset.
- Writes, rising edge: for each port w with wr_enable[w]=1 and index writable, array[idx] <= data and valid[idx] <= 1.
  - Index is not writable when ZERO_REG=1 and idx=0.
  - Same index on several ports in one cycle: the highest-numbered port wins.
- Clear: when clear=1 at an edge, all valid bits are cleared. Writes in the same cycle take precedence, so their entries end the cycle valid with the new data.
- Reads, combinational, zero latency, per port p:
  - If ZERO_REG=1 and idx=0: output 0.
  - Else if any enabled write port targets idx: output the data of the highest-numbered such port (forwarding).
  - Else if clear=1: output init(idx).
  - Else: output the effective value.
- Dump FSM states: IDLE, BEAT.
  - IDLE: on dump_start=1 at an edge, go to BEAT with ptr=0. The beat register loads dump_data with the entry-0 value as visible to the read logic in that cycle (forwarded writes/clear included).
  - BEAT: dump_valid=1, dump_index=ptr, dump_last=(ptr==DEPTH-1).
    - dump_data and dump_index are held stable while dump_ready=0, even if the entry is written meanwhile.
    - On valid&ready with ptr<DEPTH-1: ptr increments and the next entry's value, as seen by the read logic in the handshake cycle, is loaded. No bubble between beats.
    - On valid&ready with dump_last=1: go to IDLE. dump_valid, dump_busy and dump_last drop next cycle; dump_index and dump_data return to 0.
  - dump_busy=1 in BEAT.
  - dump_start is ignored while busy, including in the cycle of the final handshake.
  - Latency: dump_start at edge t gives the first beat at t+1. An unstalled dump occupies exactly DEPTH cycles.
- rst mid-dump aborts immediately to IDLE with all outputs at their reset values.
- Optional simulation-only $display on each write, matching the existing regfile debug print.

Test Plan:
- Defaults, after reset: read x2 -> 0x02000000, x5 -> 0, x0 -> 0. Write x0=0xDEAD -> x0 still reads 0.
- Forwarding and priority (NUM_WR=2): port0 writes x7=0x11 and port1 writes x7=0x22 in the same cycle. The read of x7 is 0x22 in that cycle and after the edge.
- Clear: write x3=0x55, write x2=0x1234. Assert clear together with a write x4=0x99. Next cycle x3 -> 0, x2 -> 0x02000000, x4 -> 0x99.
- Dump, ready held high: preload x1..x31 = index*3, then pulse dump_start. Exactly 32 consecutive beats with index 0..31 and data 0,3,...,93 (beat 2 = 6, since x2 was overwritten). dump_last only on beat 31; dump_busy falls the cycle after.
- Dump backpressure: hold dump_ready=0 at beat 5 for 4 cycles while writing x5=0xAAAA. The beat-5 data stays unchanged. The next dump shows 0xAAAA at beat 5.
- Reset mid-dump: assert rst during beat 10. All dump outputs go to 0 asynchronously. A fresh dump_start afterwards restarts at index 0 with default values (x2 = 0x02000000, other entries 0).

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file: N combinational read ports, M write ports with
// write-through forwarding, per-entry valid bits, bulk clear and a ready/valid dump streamer.
module regfile_mp #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 32,
    parameter int              NUM_RD   = 2,
    parameter int              NUM_WR   = 1,
    parameter int              ZERO_REG = 1,
    parameter int              SP_INDEX = 2,
    parameter logic [XLEN-1:0] SP_INIT  = 32'h02000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*$clog2(DEPTH)-1:0] rd_index,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    input  logic [NUM_WR-1:0]        wr_enable,
    input  logic [NUM_WR*$clog2(DEPTH)-1:0] wr_index,
    input  logic [NUM_WR*XLEN-1:0]   wr_data,
    input  logic                     clear,
    input  logic                     dump_start,
    output logic                     dump_busy,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [$clog2(DEPTH)-1:0] dump_index,
    output logic [XLEN-1:0]          dump_data,
    output logic                     dump_last
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic {IDLE, BEAT} state_t;

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [XLEN-1:0] beat_q, beat_d;

    function automatic logic [XLEN-1:0] init_val(input logic [AW-1:0] idx);
        return (idx == AW'(SP_INDEX)) ? SP_INIT : '0;
    endfunction

    function automatic logic writable(input logic [AW-1:0] idx);
        return !(ZERO_REG != 0 && idx == '0);
    endfunction

    // Value any reader sees this cycle: stored/init value, overridden by a pending
    // clear, overridden by enabled writes (highest port last, so it wins).
    function automatic logic [XLEN-1:0] visible(input logic [AW-1:0] idx);
        logic [XLEN-1:0] v;
        v = valid_q[idx] ? mem_q[idx] : init_val(idx);
        if (clear) v = init_val(idx);
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_enable[w] && wr_index[w*AW +: AW] == idx) v = wr_data[w*XLEN +: XLEN];
        end
        if (!writable(idx)) v = '0;
        return v;
    endfunction

    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data[p*XLEN +: XLEN] = visible(rd_index[p*AW +: AW]);
        end
    end

    // Array contents carry no reset; the valid bits decide what is observable.
    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_enable[w] && writable(wr_index[w*AW +: AW]))
                mem_q[wr_index[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (clear) valid_q <= '0;
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_enable[w] && writable(wr_index[w*AW +: AW]))
                    valid_q[wr_index[w*AW +: AW]] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
        end
    end

    // Handshake: a beat transfers on a cycle where dump_valid && dump_ready; the beat
    // register is only reloaded on a transfer, so index/data hold while stalled.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d = BEAT;
                    ptr_d   = '0;
                    beat_d  = visible('0);
                end
            end
            BEAT: begin
                if (dump_ready) begin
                    if (ptr_q == LAST_IDX) begin
                        state_d = IDLE;
                        ptr_d   = '0;
                        beat_d  = '0;
                    end else begin
                        ptr_d  = ptr_q + 1'b1;
                        beat_d = visible(ptr_q + 1'b1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dump_busy  = (state_q == BEAT);
    assign dump_valid = (state_q == BEAT);
    assign dump_last  = (state_q == BEAT) && (ptr_q == LAST_IDX);
    assign dump_index = ptr_q;
    assign dump_data  = beat_q;

endmodule
